// File: rtl/time_display_mux.sv
// Converts binary seconds/minutes to BCD and scans them onto a 4-digit common-anode
// 7-segment display, with a separator dot and optional blinking of one digit pair.
module time_display_mux #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int BLINK_HZ   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic       blink_en,
    input  logic       blink_sel,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int DIV = CLK_HZ / (REFRESH_HZ * 4);
    localparam int BPH = CLK_HZ / (2 * BLINK_HZ);
    localparam int SW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = (BPH > 1) ? $clog2(BPH) : 1;
    localparam logic [SW-1:0] SLOT_LAST  = SW'(DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BPH - 1);
    localparam logic [6:0]    SEG_DASH   = 7'b0111111;

    function automatic logic [6:0] encodeDigit(input logic [3:0] d);
        case (d)
            4'd0:    encodeDigit = 7'b1000000;
            4'd1:    encodeDigit = 7'b1111001;
            4'd2:    encodeDigit = 7'b0100100;
            4'd3:    encodeDigit = 7'b0110000;
            4'd4:    encodeDigit = 7'b0011001;
            4'd5:    encodeDigit = 7'b0010010;
            4'd6:    encodeDigit = 7'b0000010;
            4'd7:    encodeDigit = 7'b1111000;
            4'd8:    encodeDigit = 7'b0000000;
            4'd9:    encodeDigit = 7'b0010000;
            default: encodeDigit = 7'b1111111;
        endcase
    endfunction

    // Comparison chain instead of a divider; out-of-range values show a dash.
    function automatic logic [6:0] pairSegments(input logic [5:0] v, input logic wantTens);
        logic [3:0] tens;
        logic [3:0] ones;
        if      (v >= 6'd50) begin tens = 4'd5; ones = 4'(v - 6'd50); end
        else if (v >= 6'd40) begin tens = 4'd4; ones = 4'(v - 6'd40); end
        else if (v >= 6'd30) begin tens = 4'd3; ones = 4'(v - 6'd30); end
        else if (v >= 6'd20) begin tens = 4'd2; ones = 4'(v - 6'd20); end
        else if (v >= 6'd10) begin tens = 4'd1; ones = 4'(v - 6'd10); end
        else                 begin tens = 4'd0; ones = v[3:0];        end
        if (v > 6'd59)
            pairSegments = SEG_DASH;
        else
            pairSegments = encodeDigit(wantTens ? tens : ones);
    endfunction

    logic [SW-1:0] slotCnt, slotNext;
    logic [1:0]    digitIdx, digitNext;
    logic [5:0]    secSnap, minSnap, secNext, minNext;
    logic [BW-1:0] blinkCnt, blinkNext;
    logic          blinkPhase, phaseNext;
    logic          firstClk;
    logic          loadSnap;
    logic [5:0]    pairVal;
    logic [6:0]    segNext;
    logic [3:0]    anNext;
    logic          dpNext;

    // Outputs are computed from the next state so the registered outputs always match
    // the scan position held after the same edge.
    always_comb begin
        slotNext  = (slotCnt == SLOT_LAST) ? '0 : slotCnt + SW'(1);
        digitNext = (slotCnt == SLOT_LAST) ? digitIdx + 2'd1 : digitIdx;
        loadSnap  = firstClk || ((slotCnt == SLOT_LAST) && (digitIdx == 2'd3));
        secNext   = loadSnap ? seconds : secSnap;
        minNext   = loadSnap ? minutes : minSnap;
        blinkNext = (blinkCnt == BLINK_LAST) ? '0 : blinkCnt + BW'(1);
        phaseNext = (blinkCnt == BLINK_LAST) ? ~blinkPhase : blinkPhase;
        pairVal   = digitNext[1] ? minNext : secNext;
        segNext   = pairSegments(pairVal, digitNext[0]);
        dpNext    = (digitNext != 2'd2);
        anNext    = 4'b1111;
        if (slotNext != '0)
            anNext = ~(4'b0001 << digitNext);
        if (blink_en && phaseNext && (digitNext[1] == blink_sel))
            anNext = 4'b1111;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slotCnt    <= '0;
            digitIdx   <= 2'd0;
            secSnap    <= 6'd0;
            minSnap    <= 6'd0;
            blinkCnt   <= '0;
            blinkPhase <= 1'b0;
            firstClk   <= 1'b1;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            an         <= 4'b1111;
        end else begin
            slotCnt    <= slotNext;
            digitIdx   <= digitNext;
            secSnap    <= secNext;
            minSnap    <= minNext;
            blinkCnt   <= blinkNext;
            blinkPhase <= phaseNext;
            firstClk   <= 1'b0;
            seg        <= segNext;
            dp         <= dpNext;
            an         <= anNext;
        end
    end

endmodule

// File: tb/tb_time_display_mux.sv
// Randomized bench for time_display_mux: expected outputs come from a positional model
// (edge count since reset release -> slot, digit, frame, blink phase).
module tb_time_display_mux;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;
    localparam int PHASE = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] seconds, minutes;
    logic       blink_en, blink_sel;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;

    int         n = 0;
    logic [5:0] modelSec = 6'd0;
    logic [5:0] modelMin = 6'd0;
    logic       edgeBlinkEn = 1'b0;
    logic       edgeBlinkSel = 1'b0;
    logic [6:0] segTable [10];

    time_display_mux #(.CLK_HZ(400), .REFRESH_HZ(25), .BLINK_HZ(10)) dut (
        .clk(clk), .reset(reset), .seconds(seconds), .minutes(minutes),
        .blink_en(blink_en), .blink_sel(blink_sel), .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %b expected %b (n=%0d)", tag, got, exp, n);
        end
    endtask

    function automatic logic [6:0] expSeg();
        int digit;
        int v;
        int d;
        if (n == 0) return 7'b1111111;
        digit = (n / DIV) % 4;
        v = (digit >= 2) ? int'(modelMin) : int'(modelSec);
        if (v > 59) return 7'b0111111;
        d = (digit % 2 == 1) ? v / 10 : v % 10;
        return segTable[d];
    endfunction

    function automatic logic [3:0] expAn();
        int digit;
        int phase;
        if (n == 0 || (n % DIV) == 0) return 4'b1111;
        digit = (n / DIV) % 4;
        phase = (n / PHASE) % 2;
        if (edgeBlinkEn && phase == 1 && ((digit >= 2) == edgeBlinkSel)) return 4'b1111;
        return ~(4'b0001 << digit);
    endfunction

    function automatic logic expDp();
        if (n == 0) return 1'b1;
        return ((n / DIV) % 4) != 2;
    endfunction

    task automatic compareAll();
        checkOutput("seg", seg, expSeg());
        checkOutput("an", {3'b000, an}, {3'b000, expAn()});
        checkOutput("dp", {6'd0, dp}, {6'd0, expDp()});
    endtask

    task automatic applyStimulus(input logic [5:0] s, input logic [5:0] m,
                                 input logic ben, input logic bsel);
        seconds   = s;
        minutes   = m;
        blink_en  = ben;
        blink_sel = bsel;
    endtask

    // One clock: the model latches what the DUT sees at the rising edge, compare on the falling edge.
    task automatic stepCycle();
        @(posedge clk);
        n++;
        if (n == 1 || (n % FRAME) == 0) begin
            modelSec = seconds;
            modelMin = minutes;
        end
        edgeBlinkEn  = blink_en;
        edgeBlinkSel = blink_sel;
        @(negedge clk);
        compareAll();
    endtask

    task automatic runCycles(input int count);
        for (int i = 0; i < count; i++) stepCycle();
    endtask

    task automatic pulseReset();
        #2 reset = 1'b0;
        #1;
        n = 0;
        compareAll();
        @(negedge clk);
        @(negedge clk);
        compareAll();
        reset = 1'b1;
    endtask

    initial begin
        segTable[0] = 7'b1000000; segTable[1] = 7'b1111001; segTable[2] = 7'b0100100;
        segTable[3] = 7'b0110000; segTable[4] = 7'b0011001; segTable[5] = 7'b0010010;
        segTable[6] = 7'b0000010; segTable[7] = 7'b1111000; segTable[8] = 7'b0000000;
        segTable[9] = 7'b0010000;

        reset = 1'b0;
        applyStimulus(6'd37, 6'd12, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        compareAll();
        reset = 1'b1;
        compareAll();

        runCycles(2 * FRAME);
        runCycles(FRAME + 4);
        applyStimulus(6'd38, 6'd12, 1'b0, 1'b0);
        runCycles(2 * FRAME);

        applyStimulus(6'd0, 6'd60, 1'b0, 1'b0);
        runCycles(2 * FRAME);

        applyStimulus(6'd25, 6'd47, 1'b1, 1'b1);
        runCycles(3 * PHASE);
        applyStimulus(6'd25, 6'd47, 1'b1, 1'b0);
        runCycles(3 * PHASE);
        applyStimulus(6'd25, 6'd47, 1'b0, 1'b0);
        runCycles(PHASE);

        applyStimulus(6'd59, 6'd59, 1'b0, 1'b0);
        while ((n % FRAME) != FRAME - 1) stepCycle();
        runCycles(FRAME);
        applyStimulus(6'd0, 6'd0, 1'b0, 1'b0);
        runCycles(2 * FRAME);

        runCycles(7);
        pulseReset();
        runCycles(2 * FRAME);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0)
                applyStimulus(6'($urandom_range(63)), 6'($urandom_range(63)), blink_en, blink_sel);
            if ($urandom_range(31) == 0) begin
                blink_en  = 1'($urandom_range(1));
                blink_sel = 1'($urandom_range(1));
            end
            if (i == 400) pulseReset();
            stepCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
